// File: rtl/ntm_adder_stream_if.sv
// Stream bundle for ntm_adder_stream: operand input port, result output port, clear and occupancy.
// The slave modport is the adder's view; the master modport is the producer/consumer side.
interface ntm_adder_stream_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in1;
  logic [DATA_WIDTH-1:0]     in2;
  logic [1:0]                mode;
  logic                      clear;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH:0]       out;
  logic                      out_flag;
  logic [$clog2(DEPTH):0]    count;

  modport master (
    output in_valid, in1, in2, mode, clear, out_ready,
    input  in_ready, out_valid, out, out_flag, count
  );

  modport slave (
    input  in_valid, in1, in2, mode, clear, out_ready,
    output in_ready, out_valid, out, out_flag, count
  );
endinterface

// File: rtl/ntm_adder_stream.sv
// Stream adder: add / sub / saturating add / accumulate per accepted beat, results with a status
// flag queued in a circular FIFO and drained over a valid/ready port.
module ntm_adder_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input logic                clk,
  input logic                rst,
  ntm_adder_stream_if.slave  bus
);

  localparam int unsigned W  = DATA_WIDTH + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [W-1:0]  SatMax = {1'b0, {DATA_WIDTH{1'b1}}};
  localparam logic [CW-1:0] Full   = CW'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] flag_mem_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [W-1:0]     acc_q, acc_d;

  logic             push, pop;
  logic             out_valid;
  logic [W-1:0]     opa, opb, sum, diff, acc_base, res;
  logic [W:0]       acc_sum;
  logic             res_flag;

  assign bus.in_ready = (count_q != Full);
  assign out_valid    = (count_q != '0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = out_valid && bus.out_ready;

  // Result for the beat currently presented; only written when it is accepted.
  always_comb begin
    opa      = {1'b0, bus.in1};
    opb      = {1'b0, bus.in2};
    sum      = opa + opb;
    diff     = opa - opb;
    // clear wins over the old accumulator when it lands with an accumulate beat
    acc_base = bus.clear ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {1'b0, sum};
    res      = '0;
    res_flag = 1'b0;
    case (bus.mode)
      2'b00: res = sum;
      2'b01: begin
        res      = diff;
        res_flag = (bus.in1 < bus.in2);
      end
      2'b10: begin
        if (sum[W-1]) begin
          res      = SatMax;
          res_flag = 1'b1;
        end else begin
          res = sum;
        end
      end
      2'b11: begin
        res      = acc_sum[W-1:0];
        res_flag = acc_sum[W];
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (bus.clear) acc_d = '0;
    if (push && (bus.mode == 2'b11)) acc_d = acc_sum[W-1:0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= res;
      flag_mem_q[wr_ptr_q] <= res_flag;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_flag  = out_valid ? flag_mem_q[rd_ptr_q] : 1'b0;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_ntm_adder_stream.sv
// Bench for ntm_adder_stream: queue-based reference model checked every cycle, plus literal
// expectations for the directed vectors.
module tb_ntm_adder_stream;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int W     = DW + 1;
  localparam int MAXV  = (1 << DW) - 1;
  localparam int MODW  = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntm_adder_stream_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ntm_adder_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: results as plain integers in a queue.
  int mq_val[$];
  bit mq_flag[$];
  int macc;

  always @(posedge clk or negedge rst) begin
    bit mpush, mpop, f;
    int a, b, s, r;
    if (!rst) begin
      mq_val.delete();
      mq_flag.delete();
      macc = 0;
    end else begin
      mpush = bus.in_valid && (mq_val.size() != DEPTH);
      mpop  = (mq_val.size() != 0) && bus.out_ready;
      a = int'(bus.in1);
      b = int'(bus.in2);
      s = a + b;
      if (bus.clear) macc = 0;
      r = 0;
      f = 0;
      case (bus.mode)
        2'd0: r = s;
        2'd1: begin r = (a - b + MODW) % MODW; f = (a < b); end
        2'd2: begin r = (s > MAXV) ? MAXV : s; f = (s > MAXV); end
        default: begin r = (macc + s) % MODW; f = ((macc + s) >= MODW); end
      endcase
      if (mpop) begin
        void'(mq_val.pop_front());
        void'(mq_flag.pop_front());
      end
      if (mpush) begin
        mq_val.push_back(r);
        mq_flag.push_back(f);
        if (bus.mode == 2'd3) macc = r;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("cyc_in_ready", 32'(bus.in_ready), 32'(mq_val.size() != DEPTH));
      check("cyc_out_valid", 32'(bus.out_valid), 32'(mq_val.size() != 0));
      check("cyc_count", 32'(bus.count), 32'(mq_val.size()));
      if (mq_val.size() != 0) begin
        check("cyc_out", 32'(bus.out), 32'(mq_val[0]));
        check("cyc_flag", 32'(bus.out_flag), 32'(mq_flag[0]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic present(input logic [1:0] m, input int a, input int b, input bit clr);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.in1      = a[DW-1:0];
    bus.in2      = b[DW-1:0];
    bus.clear    = clr;
  endtask

  task automatic wait_accept(input string name);
    bit acc;
    acc = 0;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #2;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL %s: got no accept expected accept within 50 cycles", name);
    end
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic beat(input logic [1:0] m, input int a, input int b, input bit clr);
    present(m, a, b, clr);
    wait_accept("beat_accept");
  endtask

  task automatic lit(input string name, input int exp_out, input int exp_flag);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_out"}, 32'(bus.out), 32'(exp_out));
    check({name, "_flag"}, 32'(bus.out_flag), 32'(exp_flag));
  endtask

  task automatic drain(input string name);
    bit empty;
    empty = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && !empty; n++) begin
      empty = !bus.out_valid;
      if (!empty) cyc(1);
    end
    check({name, "_drained"}, 32'(bus.count), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.mode      = 2'd0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, with a beat offered that must be ignored.
    present(2'd0, 5, 2, 0);
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_flag", 32'(bus.out_flag), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    chk_en = 1;
    cyc(1);
    check("post_rst_count", 32'(bus.count), 32'd0);

    // Single add with one-cycle latency, then empty again.
    bus.out_ready = 1'b1;
    beat(2'd0, 5, 2, 0);
    lit("add", 7, 0);
    cyc(1);
    check("add_gone_valid", 32'(bus.out_valid), 32'd0);
    check("add_gone_count", 32'(bus.count), 32'd0);

    // Subtract and saturating add.
    beat(2'd1, 2, 5, 0);
    lit("sub", 9'h1FD, 1);
    beat(2'd2, 200, 100, 0);
    lit("sat_clamp", 255, 1);
    beat(2'd2, 100, 100, 0);
    lit("sat_pass", 200, 0);

    // Accumulate with wrap, then clear coinciding with an accumulate beat.
    beat(2'd3, 255, 255, 0);
    lit("acc1", 510, 0);
    beat(2'd3, 255, 255, 0);
    lit("acc2", 508, 1);
    beat(2'd3, 255, 255, 0);
    lit("acc3", 506, 1);
    beat(2'd3, 1, 1, 1);
    lit("acc_clear", 2, 0);
    drain("acc");

    // Backpressure: four accepted, fifth held until a slot frees.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(2'd0, 10 * i + 1, i, 0);
    check("bp_full_count", 32'(bus.count), 32'd4);
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    present(2'd0, 100, 50, 0);
    cyc(2);
    check("bp_held_count", 32'(bus.count), 32'd4);
    lit("bp_head", 1, 0);
    bus.out_ready = 1'b1;
    wait_accept("bp_fifth");
    check("bp_swap_count", 32'(bus.count), 32'd3);
    lit("bp_head2", 23, 0);
    drain("bp");

    // Asynchronous reset between edges with data buffered and acc nonzero.
    bus.out_ready = 1'b0;
    beat(2'd3, 10, 20, 0);
    beat(2'd3, 30, 40, 0);
    beat(2'd0, 1, 1, 0);
    check("ar_pre_count", 32'(bus.count), 32'd3);
    #1 rst = 1'b0;
    #1;
    check("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_in_ready", 32'(bus.in_ready), 32'd1);
    check("ar_out", 32'(bus.out), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    bus.out_ready = 1'b1;
    beat(2'd0, 5, 2, 0);
    lit("ar_add", 7, 0);
    beat(2'd3, 3, 4, 0);
    lit("ar_acc_zeroed", 7, 0);
    drain("ar");

    // Mode changes while stalled: only the accepting edge's mode counts.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(2'd0, i, i, 0);
    present(2'd1, 200, 100, 0);
    cyc(1);
    bus.mode = 2'd0;
    cyc(1);
    bus.mode = 2'd2;
    bus.out_ready = 1'b1;
    wait_accept("stall_accept");
    bus.out_ready = 1'b0;
    lit("stall_head", 4, 0);
    bus.out_ready = 1'b1;
    cyc(2);
    bus.out_ready = 1'b0;
    check("stall_count", 32'(bus.count), 32'd1);
    lit("stall_mode", 255, 1);
    drain("stall");
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
